// File: rtl/cache_ctrl_nway.sv
// Control FSM for an N-way set-associative, write-back, write-allocate cache.
// Picks a victim by lowest-invalid way, otherwise by tree pseudo-LRU, and
// sequences the multi-beat write-back and refill transfers.
// Optional hit/miss counters are enabled by defining CACHE_CTRL_PERF_CNT_EN.
module cache_ctrl_nway #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned BEATS = 1,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned BW   = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned WW   = $clog2(WAYS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  output logic             o_mem_resp,
  input  logic [WAYS-1:0]  i_hit,
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAYS-1:0]  i_dirty,
  output logic [WW-1:0]    o_way_sel,
  output logic [BW-1:0]    o_beat,
  output logic             o_load_data,
  output logic             o_load_tag,
  output logic             o_set_valid,
  output logic             o_set_dirty,
  output logic             o_set_clean,
  output logic             o_pmem_read,
  output logic             o_pmem_write,
  input  logic             i_pmem_resp,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);

  typedef enum logic [1:0] {StIdle, StCompare, StWriteBack, StAllocate} state_e;

  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

  state_e          r_state, w_state_nxt;
  logic [BW-1:0]   r_beat, w_beat_nxt;
  logic [WW-1:0]   r_victim, w_victim_nxt, w_victim, w_hit_way;
  logic [WAYS-2:0] r_plru, w_plru_nxt;
  logic            w_hit_any;

  // Lowest set bit of a way vector.
  function automatic logic [WW-1:0] first_set(input logic [WAYS-1:0] v);
    logic [WW-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = WW'(i);
    end
    return idx;
  endfunction

  // Walk the tree: a 0 bit points left, a 1 bit points right, towards the LRU side.
  function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] tree);
    logic [WW-1:0] way;
    int unsigned   node;
    logic          b;
    way  = '0;
    node = 0;
    for (int lvl = 0; lvl < WW; lvl++) begin
      b    = tree[WW'(node)];
      way  = (way << 1) | WW'(b);
      node = 2 * node + 1 + {31'b0, b};
    end
    return way;
  endfunction

  // Point every node on the path to this way away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                 input logic [WW-1:0] way);
    logic [WAYS-2:0] t;
    logic [WW-1:0]   w;
    int unsigned     node;
    logic            b;
    t    = tree;
    w    = way;
    node = 0;
    for (int lvl = 0; lvl < WW; lvl++) begin
      b              = w[WW-1];
      w              = w << 1;
      t[WW'(node)]   = ~b;
      node           = 2 * node + 1 + {31'b0, b};
    end
    return t;
  endfunction

  // State, beat, victim and PLRU registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_beat   <= '0;
      r_victim <= '0;
      r_plru   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_beat   <= w_beat_nxt;
      r_victim <= w_victim_nxt;
      r_plru   <= w_plru_nxt;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat;
    w_victim_nxt = r_victim;
    w_plru_nxt   = r_plru;
    o_mem_resp   = 1'b0;
    o_way_sel    = '0;
    o_load_data  = 1'b0;
    o_load_tag   = 1'b0;
    o_set_valid  = 1'b0;
    o_set_dirty  = 1'b0;
    o_set_clean  = 1'b0;
    o_pmem_read  = 1'b0;
    o_pmem_write = 1'b0;
    w_hit_any    = |i_hit;
    w_hit_way    = first_set(i_hit);
    w_victim     = (&i_valid) ? plru_victim(r_plru) : first_set(~i_valid);

    unique case (r_state)
      StIdle: begin
        if (i_mem_read || i_mem_write) w_state_nxt = StCompare;
      end
      StCompare: begin
        if (w_hit_any) begin
          o_way_sel   = w_hit_way;
          o_mem_resp  = 1'b1;
          // Read+write together is treated as a write.
          o_set_dirty = i_mem_write;
          w_plru_nxt  = plru_touch(r_plru, w_hit_way);
          w_state_nxt = StIdle;
        end else begin
          w_victim_nxt = w_victim;
          w_state_nxt  = i_dirty[w_victim] ? StWriteBack : StAllocate;
        end
      end
      StWriteBack: begin
        o_pmem_write = 1'b1;
        o_way_sel    = r_victim;
        if (i_pmem_resp) begin
          if (r_beat == LastBeat) begin
            o_set_clean = 1'b1;
            w_beat_nxt  = '0;
            w_state_nxt = StAllocate;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      StAllocate: begin
        o_pmem_read = 1'b1;
        o_way_sel   = r_victim;
        if (i_pmem_resp) begin
          o_load_data = 1'b1;
          if (r_beat == LastBeat) begin
            o_load_tag  = 1'b1;
            o_set_valid = 1'b1;
            w_beat_nxt  = '0;
            w_state_nxt = StCompare;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_beat = r_beat;

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic             r_refill;
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

  // Saturating counters; r_refill marks a compare that follows a refill.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_refill   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == StIdle && w_state_nxt == StCompare) begin
        r_refill <= 1'b0;
      end else if (r_state == StAllocate && w_state_nxt == StCompare) begin
        r_refill <= 1'b1;
      end
      if (r_state == StCompare && w_hit_any && !r_refill && !(&r_hit_cnt)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if (r_state == StCompare && !w_hit_any && !(&r_miss_cnt)) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`else
  assign o_hit_cnt  = '0;
  assign o_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Table-driven bench for cache_ctrl_nway with WAYS=4, BEATS=4.
// Each table row is one clock cycle: inputs applied, outputs compared.
module tb_cache_ctrl_nway;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned BEATS = 4;
  localparam int unsigned CNT_W = 32;

  // Strobe field: {load_data, load_tag, set_valid, set_dirty, set_clean, pmem_read, pmem_write}
  localparam logic [6:0] LD = 7'b1000000;
  localparam logic [6:0] LT = 7'b0100000;
  localparam logic [6:0] SV = 7'b0010000;
  localparam logic [6:0] SD = 7'b0001000;
  localparam logic [6:0] SC = 7'b0000100;
  localparam logic [6:0] PR = 7'b0000010;
  localparam logic [6:0] PW = 7'b0000001;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  hit;
    logic [3:0]  valid;
    logic [3:0]  dirty;
    logic        presp;
    logic [11:0] exp;
  } row_t;

  logic             clk;
  logic             rst;
  logic             mem_read, mem_write, mem_resp;
  logic [3:0]       hit, valid, dirty;
  logic [1:0]       way_sel, beat;
  logic             load_data, load_tag, set_valid, set_dirty, set_clean;
  logic             pmem_read, pmem_write, pmem_resp;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  row_t rows[$];
  int   n_cmp;
  int   n_fail;
  int   seg1_end;
  int   seg2_end;

  cache_ctrl_nway #(
    .WAYS (WAYS),
    .BEATS(BEATS),
    .CNT_W(CNT_W)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mem_read  (mem_read),
    .i_mem_write (mem_write),
    .o_mem_resp  (mem_resp),
    .i_hit       (hit),
    .i_valid     (valid),
    .i_dirty     (dirty),
    .o_way_sel   (way_sel),
    .o_beat      (beat),
    .o_load_data (load_data),
    .o_load_tag  (load_tag),
    .o_set_valid (set_valid),
    .o_set_dirty (set_dirty),
    .o_set_clean (set_clean),
    .o_pmem_read (pmem_read),
    .o_pmem_write(pmem_write),
    .i_pmem_resp (pmem_resp),
    .o_hit_cnt   (hit_cnt),
    .o_miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ex(input logic r, input logic [1:0] w, input logic [1:0] b,
                                     input logic [6:0] s);
    return {r, w, b, s};
  endfunction

  function automatic logic [11:0] actual();
    return {mem_resp, way_sel, beat, load_data, load_tag, set_valid, set_dirty, set_clean,
            pmem_read, pmem_write};
  endfunction

  task automatic add(input logic rd, input logic wr, input logic [3:0] h, input logic [3:0] v,
                     input logic [3:0] d, input logic pr, input logic [11:0] e);
    row_t r;
    r.rd = rd; r.wr = wr; r.hit = h; r.valid = v; r.dirty = d; r.presp = pr; r.exp = e;
    rows.push_back(r);
  endtask

  task automatic check_out(input string name, input logic [11:0] e);
    logic [11:0] a;
    a = actual();
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", name, a, e);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] a,
                           input logic [CNT_W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic run_row(input int idx);
    mem_read  = rows[idx].rd;
    mem_write = rows[idx].wr;
    hit       = rows[idx].hit;
    valid     = rows[idx].valid;
    dirty     = rows[idx].dirty;
    pmem_resp = rows[idx].presp;
    #1;
    check_out($sformatf("row%0d", idx), rows[idx].exp);
    @(posedge clk);
    #1;
  endtask

  // Request of one cycle in IDLE plus the compare cycle that hits way w.
  task automatic add_hit(input int w, input logic wr);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    add(!wr, wr, oh, 4'hF, 4'h0, 1'b0, ex(1'b0, 2'd0, 2'd0, 7'd0));
    add(!wr, wr, oh, 4'hF, 4'h0, 1'b0, ex(1'b1, 2'(w), 2'd0, wr ? SD : 7'd0));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;

    // Segment 1: hits, clean miss, dirty miss, stray pmem_resp in IDLE.
    add(1, 0, 4'b0100, 4'b0111, 4'h0, 0, ex(0, 0, 0, 0));
    add(1, 0, 4'b0100, 4'b0111, 4'h0, 0, ex(1, 2, 0, 0));
    add(0, 1, 4'b0001, 4'b0111, 4'h0, 0, ex(0, 0, 0, 0));
    add(0, 1, 4'b0001, 4'b0111, 4'h0, 0, ex(1, 0, 0, SD));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 0, ex(0, 0, 0, 0));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 0, ex(0, 0, 0, 0));        // miss, way 3 invalid
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 0, ex(0, 3, 0, PR));       // fill wait state
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 0, LD | PR));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 1, LD | PR));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 2, LD | PR));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 3, LD | LT | SV | PR));
    add(1, 0, 4'b1000, 4'hF,    4'h0, 0, ex(1, 3, 0, 0));        // re-compare hits
    // Touch order 2,0,1 leaves way 3 as the tree-PLRU victim.
    add_hit(2, 0);
    add_hit(0, 0);
    add_hit(1, 0);
    add(0, 1, 4'b0000, 4'hF, 4'b1000, 0, ex(0, 0, 0, 0));
    add(0, 1, 4'b0000, 4'hF, 4'b1000, 0, ex(0, 0, 0, 0));        // miss, victim 3 dirty
    add(0, 1, 4'b0000, 4'hF, 4'b1000, 1, ex(0, 3, 0, PW));
    add(0, 1, 4'b0000, 4'hF, 4'b1000, 0, ex(0, 3, 1, PW));       // write-back stall
    add(0, 1, 4'b0000, 4'hF, 4'b1000, 1, ex(0, 3, 1, PW));
    add(0, 1, 4'b0000, 4'hF, 4'b1000, 1, ex(0, 3, 2, PW));
    add(0, 1, 4'b0000, 4'hF, 4'b1000, 1, ex(0, 3, 3, SC | PW));
    add(0, 1, 4'b0000, 4'hF, 4'b0000, 1, ex(0, 3, 0, LD | PR));
    add(0, 1, 4'b0000, 4'hF, 4'b0000, 1, ex(0, 3, 1, LD | PR));
    add(0, 1, 4'b0000, 4'hF, 4'b0000, 1, ex(0, 3, 2, LD | PR));
    add(0, 1, 4'b0000, 4'hF, 4'b0000, 1, ex(0, 3, 3, LD | LT | SV | PR));
    add(0, 1, 4'b1000, 4'hF, 4'b0000, 0, ex(1, 3, 0, SD));
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, ex(0, 0, 0, 0));        // ignored in IDLE
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 0, ex(0, 0, 0, 0));
    seg1_end = rows.size();

    // Segment 2: clean miss up to beat 2 of the fill, then reset by hand.
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 0, ex(0, 0, 0, 0));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 0, ex(0, 0, 0, 0));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 0, LD | PR));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 1, LD | PR));
    seg2_end = rows.size();

    // Segment 3: after reset, 3 first-compare hits and one clean miss.
    add(0, 0, 4'b0000, 4'hF, 4'h0, 0, ex(0, 0, 0, 0));
    add_hit(1, 0);
    add_hit(2, 0);
    add_hit(0, 0);
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 0, ex(0, 0, 0, 0));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 0, ex(0, 0, 0, 0));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 0, LD | PR));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 1, LD | PR));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 2, LD | PR));
    add(1, 0, 4'b0000, 4'b0111, 4'h0, 1, ex(0, 3, 3, LD | LT | SV | PR));
    add(1, 0, 4'b1000, 4'hF,    4'h0, 0, ex(1, 3, 0, 0));
    add(0, 0, 4'b0000, 4'hF,    4'h0, 0, ex(0, 0, 0, 0));

    // Reset state.
    mem_read = 0; mem_write = 0; hit = '0; valid = '0; dirty = '0; pmem_resp = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_out("reset_outputs", ex(0, 0, 0, 0));
    check_cnt("reset_hit_cnt", hit_cnt, '0);
    check_cnt("reset_miss_cnt", miss_cnt, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < seg1_end; i++) run_row(i);
    for (int i = seg1_end; i < seg2_end; i++) run_row(i);

    // Now in ALLOCATE at beat 2: reset must drop pmem_read without a clock edge.
    mem_read = 1; hit = '0; valid = 4'b0111; dirty = '0; pmem_resp = 0;
    #1;
    check_out("alloc_beat2", ex(0, 3, 2, PR));
    #2 rst = 1'b1;
    #1;
    check_out("async_reset_abort", ex(0, 0, 0, 0));
    mem_read = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = seg2_end; i < rows.size(); i++) run_row(i);

`ifdef CACHE_CTRL_PERF_CNT_EN
    check_cnt("hit_cnt", hit_cnt, 32'd3);
    check_cnt("miss_cnt", miss_cnt, 32'd1);
`else
    check_cnt("hit_cnt_tied", hit_cnt, '0);
    check_cnt("miss_cnt_tied", miss_cnt, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
